// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the BRAM arbiter.
// - CPU run-mode encodings (also imported by the CPU top).
// - arb_state_t: arbiter FSM states.
// - rd_tag_t: read-response owner tag carried down the latency pipe.
// - mode_to_state(): maps a CPU mode to the arbiter state that serves it.
package mem_arbiter_pkg;

  localparam logic [1:0] MODE_STALL = 2'd0;
  localparam logic [1:0] MODE_LOAD  = 2'd1;
  localparam logic [1:0] MODE_EXEC  = 2'd2;
  localparam logic [1:0] MODE_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DM   = 2'd1,
    TAG_IF   = 2'd2
  } rd_tag_t;

  function automatic arb_state_t mode_to_state(input logic [1:0] mode);
    arb_state_t st;
    case (mode)
      MODE_STALL, MODE_STOP: st = S_IDLE;
      MODE_LOAD:             st = S_LOAD;
      MODE_EXEC:             st = S_RUN;
      default:               st = S_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and BRAM signal bundle for mem_arbiter.
// Ports (all logic):
//   loader : ld_req, ld_addr, ld_wdata -> ld_gnt
//   data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_rvalid, dm_rdata
//   fetch  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   bram   : bram_en, bram_we, bram_addr, bram_wdata <- bram_rdata
// Modports: slave = arbiter side, master = requesters plus BRAM side.
//
// Handshake: a transfer happens in exactly the cycles where req && gnt.
// gnt is combinational from req in the same cycle and never asserts without
// req. A requester keeps req, addr and wdata stable until it sees gnt.
// rvalid is a one-cycle pulse with no back-pressure; rdata is valid with it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) ();

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  bram_rdata,
    output ld_gnt,
    output dm_gnt, dm_rvalid, dm_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output ld_req, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output bram_rdata,
    input  ld_gnt,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );

endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of read-owner tags.
// Ports:
//   clk, rstn : clock, async active-low reset (clears every stage)
//   tag_in    : tag of the access issued this cycle (TAG_NONE if none/write)
//   tag_out   : tag whose BRAM data is on bram_rdata this cycle
//   busy      : any stage holds a read tag
module rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    busy
);

  rd_tag_t stage_q [RD_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

  // The tail stage counts as in flight: its data is only consumed this cycle.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (stage_q[i] != TAG_NONE) busy = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port program/data BRAM between the UART
// loader, the execute-stage data port and the fetch port, following the
// CPU run mode and draining in-flight reads before every mode change.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   mode           : CPU mode (STALL/LOAD/EXEC/STOP)
//   bus            : mem_arbiter_if.slave (requesters + BRAM)
//   ld_count       : loader words written since entering LOAD (saturating)
//   busy           : at least one read in flight
//   stat_if_stall  : S_RUN cycles with fetch denied (stats build only)
//   stat_conflict  : S_RUN cycles with data and fetch both requesting
//   dbg_state      : current FSM state
// Build option: define MEM_ARB_STATS_EN to generate the statistics
// counters; otherwise both stat outputs are tied to 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W:0]   ld_count,
  output logic              busy,
  output logic [31:0]       stat_if_stall,
  output logic [31:0]       stat_conflict,
  output arb_state_t        dbg_state
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
  localparam logic [ADDR_W:0] LD_MAX     = {1'b1, {ADDR_W{1'b0}}};

  arb_state_t        state_q, state_d, target_st;
  logic              ld_gnt, dm_gnt, if_gnt, any_gnt;
  logic [SC_W-1:0]   starve_q;
  logic              starve_hit;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              we_d;
  rd_tag_t           tag_in, tag_tail;
  logic [DATA_W-1:0] dm_rdata_d, dm_rdata_q, if_rdata_d, if_rdata_q;

  assign target_st  = mode_to_state(mode);
  assign starve_hit = (starve_q == STARVE_TOP);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and grants. Grants depend only on the current state, so
  // nothing is granted while draining.
  always_comb begin
    state_d = state_q;
    ld_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    if_gnt  = 1'b0;
    case (state_q)
      S_DRAIN: if (!busy) state_d = target_st;
      default: if (target_st != state_q) state_d = S_DRAIN;
    endcase
    case (state_q)
      S_LOAD: ld_gnt = bus.ld_req;
      S_RUN: begin
        // Data normally wins; a fetch denied STARVE_MAX times in a row wins once.
        if (bus.if_req && (!bus.dm_req || starve_hit)) if_gnt = 1'b1;
        else                                            dm_gnt = bus.dm_req;
      end
      default: ;
    endcase
  end

  assign any_gnt = ld_gnt | dm_gnt | if_gnt;

  // BRAM request mux; address/data fall back to the last driven values.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    tag_in  = TAG_NONE;
    if (ld_gnt) begin
      addr_d  = bus.ld_addr;
      wdata_d = bus.ld_wdata;
      we_d    = 1'b1;
    end else if (dm_gnt) begin
      addr_d  = bus.dm_addr;
      wdata_d = bus.dm_wdata;
      we_d    = bus.dm_we;
      tag_in  = bus.dm_we ? TAG_NONE : TAG_DM;
    end else if (if_gnt) begin
      addr_d  = bus.if_addr;
      tag_in  = TAG_IF;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Fetch starvation counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        starve_q <= '0;
    else if (!bus.if_req || if_gnt)   starve_q <= '0;
    else if (!starve_hit)             starve_q <= starve_q + 1'b1;
  end

  // Loader word counter, restarted on every entry into S_LOAD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                            ld_count <= '0;
    else if (state_q != S_LOAD && state_d == S_LOAD)      ld_count <= '0;
    else if (ld_gnt && ld_count != LD_MAX)                ld_count <= ld_count + 1'b1;
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_in),
    .tag_out (tag_tail),
    .busy    (busy)
  );

  // Response routing: the owning port sees bram_rdata directly in the tail
  // cycle; the other port keeps showing its previous response.
  always_comb begin
    dm_rdata_d = (tag_tail == TAG_DM) ? bus.bram_rdata : dm_rdata_q;
    if_rdata_d = (tag_tail == TAG_IF) ? bus.bram_rdata : if_rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
    end else begin
      dm_rdata_q <= dm_rdata_d;
      if_rdata_q <= if_rdata_d;
    end
  end

  assign bus.ld_gnt     = ld_gnt;
  assign bus.dm_gnt     = dm_gnt;
  assign bus.if_gnt     = if_gnt;
  assign bus.dm_rvalid  = (tag_tail == TAG_DM);
  assign bus.if_rvalid  = (tag_tail == TAG_IF);
  assign bus.dm_rdata   = dm_rdata_d;
  assign bus.if_rdata   = if_rdata_d;
  assign bus.bram_en    = any_gnt;
  assign bus.bram_we    = we_d;
  assign bus.bram_addr  = addr_d;
  assign bus.bram_wdata = wdata_d;
  assign dbg_state      = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_q, conflict_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else if (state_q == S_RUN) begin
      if (bus.if_req && !if_gnt)     stall_q    <= stall_q + 32'd1;
      if (bus.dm_req && bus.if_req)  conflict_q <= conflict_q + 32'd1;
    end
  end

  assign stat_if_stall = stall_q;
  assign stat_conflict = conflict_q;
`else
  assign stat_if_stall = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: a cycle table of inputs and expected
// outputs, plus a hand-written asynchronous reset sequence. A small BRAM
// model with 2-cycle read latency supplies bram_rdata; unwritten words read
// as 0xD000_0000 | address.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

`ifdef MEM_ARB_STATS_EN
  localparam logic [31:0] EXP_CONFLICT = 32'd12;
  localparam logic [31:0] EXP_STALL    = 32'd10;
`else
  localparam logic [31:0] EXP_CONFLICT = 32'd0;
  localparam logic [31:0] EXP_STALL    = 32'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic [1:0] mode;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W:0] ld_count;
  logic            busy;
  logic [31:0]     stat_if_stall, stat_conflict;
  arb_state_t      dbg_state;

  mem_arbiter dut (
    .clk           (clk),
    .rstn          (rstn),
    .mode          (mode),
    .bus           (bus),
    .ld_count      (ld_count),
    .busy          (busy),
    .stat_if_stall (stat_if_stall),
    .stat_conflict (stat_conflict),
    .dbg_state     (dbg_state)
  );

  // ---------------- BRAM model ----------------
  logic [31:0] mem [256];
  logic        wv  [256];
  logic [31:0] r1, r2;

  always @(posedge clk) begin
    if (bus.bram_en && bus.bram_we) begin
      mem[bus.bram_addr[7:0]] <= bus.bram_wdata;
      wv[bus.bram_addr[7:0]]  <= 1'b1;
    end
    if (bus.bram_en && !bus.bram_we)
      r1 <= (wv[bus.bram_addr[7:0]] === 1'b1) ? mem[bus.bram_addr[7:0]]
                                              : (32'hD000_0000 | 32'(bus.bram_addr[7:0]));
    else
      r1 <= 32'hDEAD_BEEF;
    r2 <= r1;
  end
  assign bus.bram_rdata = r2;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  md;
    logic        lq;
    logic [7:0]  la;
    logic [31:0] lw;
    logic        dq;
    logic        dwe;
    logic [7:0]  da;
    logic [31:0] dd;
    logic        iq;
    logic [7:0]  ia;
    logic [2:0]  g;     // {ld, dm, if} grants
    logic        ewe;
    logic [7:0]  ea;
    logic [31:0] ewd;
    logic [1:0]  rv;    // {dm, if} rvalid
    logic [31:0] rd;
    arb_state_t  st;
    logic        bz;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cur_row = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", nm, cur_row, act, exp);
    end
  endtask

  function automatic void add_vec(
    input logic [1:0] md, input logic lq, input logic [7:0] la, input logic [31:0] lw,
    input logic dq, input logic dwe, input logic [7:0] da, input logic [31:0] dd,
    input logic iq, input logic [7:0] ia,
    input logic [2:0] g, input logic [7:0] ea, input logic [31:0] ewd,
    input logic [1:0] rv, input logic [31:0] rd,
    input arb_state_t st, input logic bz, input logic [15:0] cnt);
    vec_t v;
    v.md = md; v.lq = lq; v.la = la; v.lw = lw;
    v.dq = dq; v.dwe = dwe; v.da = da; v.dd = dd;
    v.iq = iq; v.ia = ia;
    v.g = g; v.ewe = g[2] | (g[1] & dwe); v.ea = ea; v.ewd = ewd;
    v.rv = rv; v.rd = rd; v.st = st; v.bz = bz; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  function automatic logic cont_if(input int k);
    return (k == 4) || (k == 9);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    mode         = v.md;
    bus.ld_req   = v.lq;  bus.ld_addr = ADDR_W'(v.la); bus.ld_wdata = v.lw;
    bus.dm_req   = v.dq;  bus.dm_we   = v.dwe;
    bus.dm_addr  = ADDR_W'(v.da); bus.dm_wdata = v.dd;
    bus.if_req   = v.iq;  bus.if_addr = ADDR_W'(v.ia);
  endtask

  task automatic check_vec(input vec_t v);
    chk("ld_gnt",    32'(bus.ld_gnt),    32'(v.g[2]));
    chk("dm_gnt",    32'(bus.dm_gnt),    32'(v.g[1]));
    chk("if_gnt",    32'(bus.if_gnt),    32'(v.g[0]));
    chk("bram_en",   32'(bus.bram_en),   32'(|v.g));
    chk("bram_we",   32'(bus.bram_we),   32'(v.ewe));
    chk("bram_addr", 32'(bus.bram_addr), 32'(v.ea));
    if (v.ewe) chk("bram_wdata", bus.bram_wdata, v.ewd);
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(v.rv[1]));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(v.rv[0]));
    if (v.rv[1]) chk("dm_rdata", bus.dm_rdata, v.rd);
    if (v.rv[0]) chk("if_rdata", bus.if_rdata, v.rd);
    chk("state",     32'(dbg_state),     32'(v.st));
    chk("busy",      32'(busy),          32'(v.bz));
    chk("ld_count",  32'(ld_count),      32'(v.cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ld_gnt"},     32'(bus.ld_gnt),    32'd0);
    chk({tag, "_dm_gnt"},     32'(bus.dm_gnt),    32'd0);
    chk({tag, "_if_gnt"},     32'(bus.if_gnt),    32'd0);
    chk({tag, "_dm_rvalid"},  32'(bus.dm_rvalid), 32'd0);
    chk({tag, "_if_rvalid"},  32'(bus.if_rvalid), 32'd0);
    chk({tag, "_dm_rdata"},   bus.dm_rdata,       32'd0);
    chk({tag, "_if_rdata"},   bus.if_rdata,       32'd0);
    chk({tag, "_bram_en"},    32'(bus.bram_en),   32'd0);
    chk({tag, "_bram_we"},    32'(bus.bram_we),   32'd0);
    chk({tag, "_bram_addr"},  32'(bus.bram_addr), 32'd0);
    chk({tag, "_bram_wdata"}, bus.bram_wdata,     32'd0);
    chk({tag, "_busy"},       32'(busy),          32'd0);
    chk({tag, "_ld_count"},   32'(ld_count),      32'd0);
    chk({tag, "_stall"},      stat_if_stall,      32'd0);
    chk({tag, "_conflict"},   stat_conflict,      32'd0);
    chk({tag, "_state"},      32'(dbg_state),     32'(S_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- test ----------------
  initial begin
    // Row 0..2: idle, then IDLE -> DRAIN -> LOAD with requests pending.
    add_vec(0, 0,8'h00,0, 0,0,8'h00,0, 0,8'h00, 3'b000, 8'h00,0, 2'b00,0, S_IDLE, 0, 0);
    add_vec(1, 1,8'h00,32'hA0, 1,0,8'h05,0, 0,8'h00, 3'b000, 8'h00,0, 2'b00,0, S_IDLE, 0, 0);
    add_vec(1, 1,8'h00,32'hA0, 1,0,8'h05,0, 0,8'h00, 3'b000, 8'h00,0, 2'b00,0, S_DRAIN, 0, 0);
    // Rows 3..10: loader burst, data port requesting but never granted.
    for (int i = 0; i < 8; i++)
      add_vec(1, 1,8'(i),32'hA0 + 32'(i), 1,0,8'h05,0, 0,8'h00,
              3'b100, 8'(i),32'hA0 + 32'(i), 2'b00,0, S_LOAD, 0, 16'(i));
    add_vec(1, 0,0,0, 0,0,0,0, 0,0, 3'b000, 8'h07,0, 2'b00,0, S_LOAD,  0, 8);  // 11
    add_vec(2, 0,0,0, 0,0,0,0, 0,0, 3'b000, 8'h07,0, 2'b00,0, S_LOAD,  0, 8);  // 12
    add_vec(2, 0,0,0, 0,0,0,0, 0,0, 3'b000, 8'h07,0, 2'b00,0, S_DRAIN, 0, 8);  // 13
    // Row 14: data read of a loaded word; 15: mode switch with it in flight.
    add_vec(2, 0,0,0, 1,0,8'h03,0, 0,0, 3'b010, 8'h03,0, 2'b00,0, S_RUN, 0, 8);
    add_vec(1, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h03,0, 2'b00,0, S_RUN, 1, 8);
    add_vec(1, 0,0,0, 1,0,8'h09,0, 0,0, 3'b000, 8'h03,0, 2'b10,32'hA3, S_DRAIN, 1, 8);
    add_vec(1, 0,0,0, 1,0,8'h09,0, 0,0, 3'b000, 8'h03,0, 2'b00,0, S_DRAIN, 0, 8);
    add_vec(1, 0,0,0, 1,0,8'h09,0, 0,0, 3'b000, 8'h03,0, 2'b00,0, S_LOAD,  0, 0);
    add_vec(2, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h03,0, 2'b00,0, S_LOAD,  0, 0);  // 19
    add_vec(2, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h03,0, 2'b00,0, S_DRAIN, 0, 0);  // 20
    // Rows 21..35: 12 cycles of data/fetch contention, then tail-off.
    for (int k = 0; k <= 14; k++)
      add_vec(2, 0,0,0, k < 12,0,8'h20,0, k < 12,8'h10,
              (k < 12) ? (cont_if(k) ? 3'b001 : 3'b010) : 3'b000,
              (k < 12 && cont_if(k)) ? 8'h10 : 8'h20, 0,
              (k >= 2 && k < 14) ? (cont_if(k-2) ? 2'b01 : 2'b10) : 2'b00,
              (k >= 2 && k < 14) ? (cont_if(k-2) ? 32'hD000_0010 : 32'hD000_0020) : 32'h0,
              S_RUN, (k >= 1 && k <= 13), 0);
    // Rows 36..42: alternating fetch @0x10 / data @0x20 back to back.
    for (int j = 0; j <= 6; j++)
      add_vec(2, 0,0,0, (j < 4 && j % 2 == 1),0,8'h20,0, (j < 4 && j % 2 == 0),8'h10,
              (j < 4) ? ((j % 2 == 0) ? 3'b001 : 3'b010) : 3'b000,
              (j < 4 && j % 2 == 0) ? 8'h10 : 8'h20, 0,
              (j >= 2 && j < 6) ? (((j-2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00,
              (j >= 2 && j < 6) ? (((j-2) % 2 == 0) ? 32'hD000_0010 : 32'hD000_0020) : 32'h0,
              S_RUN, (j >= 1 && j <= 5), 0);
    // Rows 43..47: data write (no tag, no rvalid) then read-back.
    add_vec(2, 0,0,0, 1,1,8'h30,32'h1234_5678, 0,0, 3'b010, 8'h30,32'h1234_5678, 2'b00,0, S_RUN, 0, 0);
    add_vec(2, 0,0,0, 1,0,8'h30,0, 0,0, 3'b010, 8'h30,0, 2'b00,0, S_RUN, 0, 0);
    add_vec(2, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h30,0, 2'b00,0, S_RUN, 1, 0);
    add_vec(2, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h30,0, 2'b10,32'h1234_5678, S_RUN, 1, 0);
    add_vec(2, 0,0,0, 0,0,0,0,     0,0, 3'b000, 8'h30,0, 2'b00,0, S_RUN, 0, 0);

    // Reset
    rstn = 1'b0;
    mode = 2'd0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Table
    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      cur_row = r;
      drive_vec(vecs[r]);
      #1;
      check_vec(vecs[r]);
    end
    cur_row = -1;
    chk("stat_conflict", stat_conflict, EXP_CONFLICT);
    chk("stat_if_stall", stat_if_stall, EXP_STALL);

    // Async reset with two reads in flight
    @(negedge clk);
    drive_idle();
    bus.if_req = 1'b1; bus.if_addr = ADDR_W'(8'h10);
    #1;
    chk("rst_seq_if_gnt", 32'(bus.if_gnt), 32'd1);
    @(negedge clk);
    drive_idle();
    bus.dm_req = 1'b1; bus.dm_addr = ADDR_W'(8'h20);
    #1;
    chk("rst_seq_dm_gnt", 32'(bus.dm_gnt), 32'd1);
    @(negedge clk);
    bus.dm_req = 1'b1;
    #1;
    chk("rst_seq_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    mode = 2'd0;
    drive_idle();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
      chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("post_rst_busy",      32'(busy),          32'd0);
      chk("post_rst_state",     32'(dbg_state),     32'(S_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
